softmax_norm: RTL and testbench
===============================

Name: softmax_norm

Overview:
- Downstream normalisation stage of the STAR softmax datapath.
- Consumes the N per-element exp values produced by the LUT stage and accumulates their sum internally.
- Emits each probability p_i = exp_i / sum(exp) as an unsigned Q0.16 fraction.
- Buffers one full vector, then divides element by element with a bit-serial restoring divider.

Parameters:
- N, 16: elements per softmax vector (matches Input_len).
- W, 32: exp input width.
- QW, 16: output fraction width.
- CW, $clog2(N): index/counter width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- exp_in  input  W  exp value of current element
- exp_valid  input  1  exp_in valid this cycle
- exp_ready  output  1  block accepts exp_in (high only in IDLE/COLLECT)
- prob  output  QW  normalised probability, Q0.16
- prob_idx  output  CW  element index of prob
- prob_valid  output  1  prob/prob_idx valid
- prob_ready  input  1  consumer accepts prob
- sum_zero  output  1  vector sum was zero (sticky until next vector starts)
- done  output  1  one-cycle pulse after last element accepted by consumer

Behaviour:
- Reset (async, any state): state=IDLE, buffer/sum/counters cleared, exp_ready=1, prob=0, prob_idx=0, prob_valid=0, sum_zero=0, done=0.
- Storage: buffer of N entries x W bits. Accumulator is W+CW bits wide and never overflows.
- Input handshake: a transfer occurs when exp_valid && exp_ready.
- State IDLE:
  - On transfer: buf[0]=exp_in, sum=exp_in, cnt=1, clear sum_zero, go to COLLECT.
- State COLLECT:
  - Each transfer: buf[cnt]=exp_in, sum+=exp_in.
  - On the transfer with cnt==N-1: go to DIVIDE, idx=0; exp_ready drops the next cycle.
- State DIVIDE:
  - Computes Q = floor((buf[idx] << QW) / sum), one quotient bit per cycle, restoring algorithm, MSB first.
  - QW+1 iterations (quotient can equal 2^QW when buf[idx]==sum).
  - Then go to OUTPUT.
  - sum==0: skip iterations, Q=0, set sum_zero, go directly to OUTPUT.
- State OUTPUT:
  - prob = (Q >= 2^QW) ? 2^QW-1 : Q[QW-1:0] (saturation), prob_idx=idx, prob_valid=1.
  - prob, prob_idx and prob_valid hold stable while prob_ready=0.
  - On prob_valid && prob_ready: prob_valid=0 the next cycle.
    - idx<N-1: idx++, go to DIVIDE.
    - Else: done=1 for one cycle, go to IDLE.
- Latency: first prob_valid appears QW+2 = 18 cycles after the last input transfer (rounding off). Each further element takes QW+2 cycles plus any stall.
- exp_valid while exp_ready=0 is ignored; no data is lost, the upstream holds.
- Only the per-vector sum matters; elements with exp=0 produce prob=0.
- Reset asserted mid-DIVIDE/OUTPUT: the vector is discarded and no done pulse is produced.
- Output ordering is idx 0..N-1, strictly ascending.

Optional Feature:
- Macro SOFTMAX_ROUND_EN.
- Defined:
  - Divider runs QW+2 iterations, producing one extra fraction bit.
  - Q_r = (Q + 1) >> 1 (round half up), then the same saturation to 2^QW-1.
  - DIVIDE takes one more cycle per element.
- Undefined: truncation, exactly as described above.

Test Plan:
- 16 x exp=0x100 -> sum=0x1000. Every prob=0x1000, idx 0..15 in order, one done pulse, sum_zero=0.
- exp=[1,3,0 x14] -> prob[0]=0x4000, prob[1]=0xC000, rest 0x0000.
- exp=[5 at idx 7, else 0] -> prob[7]=0xFFFF (saturated), all others 0.
- exp=[1,2,0 x14]:
  - Without SOFTMAX_ROUND_EN: prob[0]=0x5555, prob[1]=0xAAAA.
  - With SOFTMAX_ROUND_EN: 0x5555, 0xAAAB.
- All 16 exp=0 -> sum_zero=1, all prob=0, done pulses.
- Backpressure and reset:
  - Hold prob_ready=0 for 10 cycles during idx 3 -> prob/prob_idx stable, no skip or duplicate.
  - Assert reset during DIVIDE of idx 5 -> all outputs return to reset values at once, no done.
  - After reset, a new vector processes correctly.

Source files
------------

// File: rtl/softmax_norm.sv
// softmax_norm: buffers one vector of N exp values, then emits exp_i/sum as Q0.16 via a bit-serial restoring divider.
// Optional macro SOFTMAX_ROUND_EN: one extra quotient bit and round-half-up instead of truncation.
module softmax_norm #(
   parameter int unsigned N  = 16,
   parameter int unsigned W  = 32,
   parameter int unsigned QW = 16,
   parameter int unsigned CW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [W-1:0]  exp_in,
   input  logic          exp_valid,
   output logic          exp_ready,
   output logic [QW-1:0] prob,
   output logic [CW-1:0] prob_idx,
   output logic          prob_valid,
   input  logic          prob_ready,
   output logic          sum_zero,
   output logic          done
);

   localparam int unsigned SUMW = W + CW;
`ifdef SOFTMAX_ROUND_EN
   localparam int unsigned K = QW + 2;
`else
   localparam int unsigned K = QW + 1;
`endif
   localparam int unsigned SW = $clog2(K);

   typedef enum logic [1:0] {IDLE, COLLECT, DIVIDE, OUTPUT} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    mem_q [N];
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [SUMW-1:0] sum_q, sum_d;
   logic [SUMW-1:0] rem_q, rem_d;
   logic [K-1:0]    dbits_q, dbits_d;
   logic [K-1:0]    quo_q, quo_d;
   logic [SW-1:0]   step_q, step_d;
   logic            init_q, init_d;
   logic            exp_ready_q, exp_ready_d;
   logic [QW-1:0]   prob_q, prob_d;
   logic            prob_valid_q, prob_valid_d;
   logic            sum_zero_q, sum_zero_d;
   logic            done_q, done_d;

   logic            mem_we_c;
   logic            ge_c;
   logic [W-1:0]    cur_c;
   logic [SUMW:0]   rem_sh_c;
   logic [SUMW:0]   rem_sub_c;
   logic [K-1:0]    quo_nx_c;
   logic [QW:0]     q_fin_c;

   // One restoring step: shift in the next dividend bit, subtract the sum if it fits.
   assign cur_c     = mem_q[idx_q];
   assign rem_sh_c  = {rem_q, dbits_q[K-1]};
   assign ge_c      = (rem_sh_c >= {1'b0, sum_q});
   assign rem_sub_c = rem_sh_c - {1'b0, sum_q};
   assign quo_nx_c  = {quo_q[K-2:0], ge_c};

`ifdef SOFTMAX_ROUND_EN
   logic [K:0] q_inc_c;
   assign q_inc_c = {1'b0, quo_nx_c} + (K+1)'(1);
   assign q_fin_c = (QW+1)'(q_inc_c >> 1);
`else
   assign q_fin_c = quo_nx_c;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      sum_d        = sum_q;
      rem_d        = rem_q;
      dbits_d      = dbits_q;
      quo_d        = quo_q;
      step_d       = step_q;
      init_d       = init_q;
      prob_d       = prob_q;
      prob_valid_d = prob_valid_q;
      sum_zero_d   = sum_zero_q;
      done_d       = 1'b0;
      mem_we_c     = 1'b0;

      case (state_q)
         IDLE: begin
            if (exp_valid && exp_ready_q) begin
               mem_we_c   = 1'b1;
               sum_d      = SUMW'(exp_in);
               cnt_d      = CW'(1);
               sum_zero_d = 1'b0;
               state_d    = COLLECT;
            end
         end
         COLLECT: begin
            if (exp_valid && exp_ready_q) begin
               mem_we_c = 1'b1;
               sum_d    = sum_q + SUMW'(exp_in);
               if (cnt_q == CW'(N-1)) begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  init_d  = 1'b1;
                  state_d = DIVIDE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         DIVIDE: begin
            if (init_q) begin
               // Quotient is at most 2^QW since each element is part of the sum,
               // so the top dividend bits collapse into an initial remainder of elem>>1.
               init_d = 1'b0;
               if (sum_q == '0) begin
                  prob_d       = '0;
                  prob_valid_d = 1'b1;
                  sum_zero_d   = 1'b1;
                  state_d      = OUTPUT;
               end else begin
                  rem_d          = SUMW'(cur_c >> 1);
                  dbits_d        = '0;
                  dbits_d[K-1]   = cur_c[0];
                  quo_d          = '0;
                  step_d         = '0;
               end
            end else begin
               rem_d   = ge_c ? SUMW'(rem_sub_c) : SUMW'(rem_sh_c);
               dbits_d = {dbits_q[K-2:0], 1'b0};
               quo_d   = quo_nx_c;
               step_d  = step_q + SW'(1);
               if (step_q == SW'(K-1)) begin
                  prob_d       = q_fin_c[QW] ? '1 : q_fin_c[QW-1:0];
                  prob_valid_d = 1'b1;
                  state_d      = OUTPUT;
               end
            end
         end
         OUTPUT: begin
            if (prob_valid_q && prob_ready) begin
               prob_valid_d = 1'b0;
               if (idx_q == CW'(N-1)) begin
                  idx_d   = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + CW'(1);
                  init_d  = 1'b1;
                  state_d = DIVIDE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      exp_ready_d = (state_d == IDLE) || (state_d == COLLECT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         sum_q        <= '0;
         rem_q        <= '0;
         dbits_q      <= '0;
         quo_q        <= '0;
         step_q       <= '0;
         init_q       <= 1'b0;
         exp_ready_q  <= 1'b1;
         prob_q       <= '0;
         prob_valid_q <= 1'b0;
         sum_zero_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         sum_q        <= sum_d;
         rem_q        <= rem_d;
         dbits_q      <= dbits_d;
         quo_q        <= quo_d;
         step_q       <= step_d;
         init_q       <= init_d;
         exp_ready_q  <= exp_ready_d;
         prob_q       <= prob_d;
         prob_valid_q <= prob_valid_d;
         sum_zero_q   <= sum_zero_d;
         done_q       <= done_d;
      end
   end

   // Vector buffer; cnt is zero in IDLE so the first element lands in entry 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N; i++) mem_q[i] <= '0;
      end else if (mem_we_c) begin
         mem_q[cnt_q] <= exp_in;
      end
   end

   assign exp_ready  = exp_ready_q;
   assign prob       = prob_q;
   assign prob_idx   = idx_q;
   assign prob_valid = prob_valid_q;
   assign sum_zero   = sum_zero_q;
   assign done       = done_q;

endmodule

// File: tb/tb_softmax_norm.sv
// tb_softmax_norm: directed vectors with hand-computed probabilities, backpressure and mid-vector reset.
module tb_softmax_norm;

   logic        clk;
   logic        reset;
   logic [31:0] exp_in;
   logic        exp_valid;
   logic        exp_ready;
   logic [15:0] prob;
   logic [3:0]  prob_idx;
   logic        prob_valid;
   logic        prob_ready;
   logic        sum_zero;
   logic        done;

   int n_chk;
   int n_fail;
   int stall_idx;

   logic [31:0] vec  [16];
   logic [15:0] expv [16];

`ifdef SOFTMAX_ROUND_EN
   localparam int LAT = 19;
   localparam logic [15:0] P12_1 = 16'hAAAB;
`else
   localparam int LAT = 18;
   localparam logic [15:0] P12_1 = 16'hAAAA;
`endif

   softmax_norm dut (
      .clk        (clk),
      .reset      (reset),
      .exp_in     (exp_in),
      .exp_valid  (exp_valid),
      .exp_ready  (exp_ready),
      .prob       (prob),
      .prob_idx   (prob_idx),
      .prob_valid (prob_valid),
      .prob_ready (prob_ready),
      .sum_zero   (sum_zero),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expd);
      n_chk++;
      assert (obs === expd) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expd);
      end
   endtask

   task automatic fill(input logic [31:0] e, input logic [15:0] p);
      for (int i = 0; i < 16; i++) begin
         vec[i]  = e;
         expv[i] = p;
      end
   endtask

   task automatic send_vec(input string tn);
      logic acc;
      int   guard;
      for (int i = 0; i < 16; i++) begin
         exp_in    = vec[i];
         exp_valid = 1'b1;
         acc       = 1'b0;
         guard     = 0;
         while (!acc && guard < 50) begin
            acc = exp_ready;
            @(posedge clk); #1;
            guard++;
         end
         if (!acc) chk({tn, " send_timeout"}, 64'd0, 64'd1);
      end
      exp_valid = 1'b0;
      exp_in    = '0;
   endtask

   task automatic collect(input string tn, input int n, input int lat, input logic sz);
      int guard;
      prob_ready = 1'b1;
      for (int k = 0; k < n; k++) begin
         guard = 0;
         while (!prob_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
         end
         if (!prob_valid) begin
            chk($sformatf("%s valid_timeout idx%0d", tn, k), 64'd0, 64'd1);
            break;
         end
         if (k == 0 && lat > 0) chk({tn, " latency"}, 64'(guard), 64'(lat));
         chk($sformatf("%s idx%0d", tn, k), 64'(prob_idx), 64'(k));
         chk($sformatf("%s prob%0d", tn, k), 64'(prob), 64'(expv[k]));
         if (k == stall_idx) begin
            prob_ready = 1'b0;
            for (int s = 0; s < 10; s++) begin
               @(posedge clk); #1;
               chk($sformatf("%s stall%0d valid", tn, s), 64'(prob_valid), 64'd1);
               chk($sformatf("%s stall%0d idx", tn, s), 64'(prob_idx), 64'(k));
               chk($sformatf("%s stall%0d prob", tn, s), 64'(prob), 64'(expv[k]));
            end
            prob_ready = 1'b1;
         end
         @(posedge clk); #1;
         chk($sformatf("%s valid_drop%0d", tn, k), 64'(prob_valid), 64'd0);
         chk($sformatf("%s done%0d", tn, k), 64'(done), (k == 15) ? 64'd1 : 64'd0);
      end
      if (n == 16) begin
         @(posedge clk); #1;
         chk({tn, " done_pulse_end"}, 64'(done), 64'd0);
         chk({tn, " sum_zero"}, 64'(sum_zero), 64'(sz));
         chk({tn, " exp_ready_idle"}, 64'(exp_ready), 64'd1);
      end
   endtask

   task automatic chk_reset_vals(input string tn);
      chk({tn, " exp_ready"}, 64'(exp_ready), 64'd1);
      chk({tn, " prob"}, 64'(prob), 64'd0);
      chk({tn, " prob_idx"}, 64'(prob_idx), 64'd0);
      chk({tn, " prob_valid"}, 64'(prob_valid), 64'd0);
      chk({tn, " sum_zero"}, 64'(sum_zero), 64'd0);
      chk({tn, " done"}, 64'(done), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      stall_idx  = -1;
      reset      = 1'b1;
      exp_in     = '0;
      exp_valid  = 1'b0;
      prob_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("por");
      reset = 1'b0;
      @(posedge clk); #1;

      // Uniform vector: 0x100/0x1000 = 1/16.
      fill(32'h100, 16'h1000);
      send_vec("uni");
      chk("uni exp_ready_drop", 64'(exp_ready), 64'd0);
      collect("uni", 16, LAT, 1'b0);

      // [1,3,0...]: quarter and three quarters; exp_valid while not ready is ignored.
      fill(32'd0, 16'h0000);
      vec[0] = 32'd1; expv[0] = 16'h4000;
      vec[1] = 32'd3; expv[1] = 16'hC000;
      send_vec("q13");
      exp_valid = 1'b1;
      exp_in    = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      #1;
      chk("q13 exp_ready_busy", 64'(exp_ready), 64'd0);
      exp_valid = 1'b0;
      exp_in    = '0;
      collect("q13", 16, 0, 1'b0);

      // Single non-zero element: quotient 2^16 saturates.
      fill(32'd0, 16'h0000);
      vec[7] = 32'd5; expv[7] = 16'hFFFF;
      send_vec("sat");
      collect("sat", 16, 0, 1'b0);

      // [1,2,0...]: thirds, truncated or rounded.
      fill(32'd0, 16'h0000);
      vec[0] = 32'd1; expv[0] = 16'h5555;
      vec[1] = 32'd2; expv[1] = P12_1;
      send_vec("thr");
      collect("thr", 16, 0, 1'b0);

      // All zero: sticky sum_zero, every prob 0.
      fill(32'd0, 16'h0000);
      send_vec("zero");
      collect("zero", 16, 0, 1'b1);

      // Ramp summing to 256: prob_i = (i+1)*0x100, last 136*0x100; stall on idx 3.
      for (int i = 0; i < 15; i++) begin
         vec[i]  = 32'(i + 1);
         expv[i] = 16'((i + 1) * 256);
      end
      vec[15] = 32'd136; expv[15] = 16'h8800;
      stall_idx = 3;
      send_vec("bp");
      collect("bp", 16, 0, 1'b0);
      stall_idx = -1;

      // Same ramp, reset asserted mid-cycle during the divide of idx 5.
      send_vec("rst");
      collect("rst", 5, 0, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("mid_rst");
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk($sformatf("mid_rst hold%0d done", c), 64'(done), 64'd0);
         chk($sformatf("mid_rst hold%0d valid", c), 64'(prob_valid), 64'd0);
      end
      reset = 1'b0;
      @(posedge clk); #1;

      // Fresh vector after reset.
      fill(32'd0, 16'h0000);
      vec[0] = 32'd1; expv[0] = 16'h4000;
      vec[1] = 32'd3; expv[1] = 16'hC000;
      send_vec("post");
      collect("post", 16, LAT, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
